hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Pipeline stall/flush sequencer for the 5-stage MIPS core, sitting beside the forwarding logic in the ID/EX boundary region.
- Detects load-use hazards that forwarding cannot cover.
- Sequences multi-cycle mult/div occupancy of EX with a down-counter FSM.
- Flushes wrong-path instructions on a taken branch resolved in EX.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register address width.
MD_LATENCY, 32, total cycles a mult/div occupies EX; legal range 2..255.
CNT_W, 16, width of the performance counters.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_n_i  in  1  asynchronous active-low reset.
id_rs_i  in  REG_ADDR_W  rs field of the instruction in ID.
id_rt_i  in  REG_ADDR_W  rt field of the instruction in ID.
id_uses_rt_i  in  1  instruction in ID reads rt as a source.
ex_rt_i  in  REG_ADDR_W  destination register of the instruction in EX (load target).
ex_mem_read_i  in  1  instruction in EX is a load.
ex_muldiv_i  in  1  instruction in EX is mult/div.
ex_branch_taken_i  in  1  branch or jump in EX resolved taken.
cnt_clr_i  in  1  synchronous clear of both performance counters.
pc_write_o  out  1  PC update enable.
if_id_write_o  out  1  IF/ID register enable.
if_id_flush_o  out  1  IF/ID register loads a NOP.
id_ex_write_o  out  1  ID/EX register enable.
id_ex_flush_o  out  1  ID/EX register loads a bubble (control bits zeroed).
ex_mem_flush_o  out  1  EX/MEM register loads a bubble.
md_busy_o  out  1  FSM in MD_WAIT.
md_done_o  out  1  last EX cycle of a mult/div; result valid.
stall_cnt_o  out  CNT_W  cycles with pc_write_o=0.
flush_cnt_o  out  CNT_W  number of taken-branch flushes.

Behaviour:
Reset (asynchronous; outputs forced while rst_n_i=0):
- Registers: state=RUN, md_cnt=0, stall_cnt_o=0, flush_cnt_o=0.
- Outputs: pc_write_o=0, if_id_write_o=0, id_ex_write_o=0, if_id_flush_o=1, id_ex_flush_o=1, ex_mem_flush_o=0, md_busy_o=0, md_done_o=0.
- Reset asserted mid mult/div abandons the operation; no md_done_o is produced.

Outputs are combinational from state, md_cnt and the inputs; zero added latency. Default (RUN, no event): all *_write_o=1, all *_flush_o=0.

Priority in RUN (highest first):
1. ex_branch_taken_i: pc_write_o=1, if_id_flush_o=1, id_ex_flush_o=1. flush_cnt_o increments. Any coincident load-use is discarded.
2. ex_muldiv_i:
   - Outputs: pc_write_o=0, if_id_write_o=0, id_ex_write_o=0, ex_mem_flush_o=1.
   - Next state: md_cnt<=MD_LATENCY-2, state<=MD_WAIT.
3. Load-use, defined as ex_mem_read_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)):
   - Outputs: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1.
   - Lasts exactly one cycle; the load then advances to MEM and the forwarding unit covers the dependency.

MD_WAIT (ex_muldiv_i, ex_branch_taken_i and load-use are all ignored):
- md_cnt!=0: same stall outputs as entry (PC, IF/ID and ID/EX held; EX/MEM bubbled); md_cnt decrements.
- md_cnt==0: release cycle. Default outputs, md_done_o=1, state<=RUN.
- Total EX occupancy is exactly MD_LATENCY cycles; md_busy_o=1 for MD_LATENCY-1 of them.

Counters:
- stall_cnt_o increments each cycle pc_write_o=0.
- Both counters saturate at all-ones; no wrap-around.
- cnt_clr_i wins over a coincident increment.

Decomposition:
- Shared package/defines: FSM state encoding (RUN=0, MD_WAIT=1), the existing R_WIDTH register-width define, and the NOP/bubble convention.
- Sub-module: hazard_md_timer (loadable down-counter with a zero flag).
- Hazard compare and output mux stay in the top level.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rt_i=8, id_rs_i=8 -> one cycle of pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; next cycle defaults; stall_cnt_o=1. Repeat with ex_rt_i=0 -> no stall. Repeat with rt match and id_uses_rt_i=0 -> no stall.
- Branch: ex_branch_taken_i=1 -> if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1; flush_cnt_o=1. Assert with a simultaneous load-use -> branch response only, stall_cnt_o unchanged.
- Mult/div, MD_LATENCY=4: ex_muldiv_i held for 4 cycles -> stall outputs for 3 cycles, md_busy_o=1 for 3, md_done_o=1 in cycle 4, then RUN. Repeat with MD_LATENCY=2 -> exactly 1 stall cycle.
- Reset mid MD_WAIT: drop rst_n_i after 2 stall cycles -> immediate reset output values, state RUN, counters 0, no md_done_o.
- Saturation: preload stall_cnt_o to 0xFFFE, apply 3 stall cycles -> holds 0xFFFF. Then cnt_clr_i during a stall -> 0.
- In MD_WAIT: pulse ex_branch_taken_i and a load-use match -> ignored; stall sequence and cycle count unchanged.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control slice: FSM encoding,
// core register width and the NOP/bubble convention.
package hazard_ctrl_unit_pkg;

  // Sequencer states: normal issue, or EX occupied by a mult/div.
  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  // Datapath register width of the core.
  localparam int R_WIDTH = 32;

  // A flushed IF/ID slot holds sll $0,$0,0 (all zeros); a bubbled
  // ID/EX or EX/MEM slot has every control bit cleared.
  localparam logic [R_WIDTH-1:0] NOP_INSTR = '0;

  // Width of the mult/div occupancy counter (MD_LATENCY <= 255).
  localparam int MD_CNT_W = 8;

endpackage

// File: rtl/hazard_md_timer.sv
// Loadable down-counter with a zero flag, used to time mult/div
// occupancy of the EX stage.
module hazard_md_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; the count never goes below zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_count <= '0;
    else if (load_i)
      r_count <= load_val_i;
    else if (dec_i && (r_count != '0))
      r_count <= r_count - W'(1);
  end

  assign count_o = r_count;
  assign zero_o  = (r_count == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline stall/flush sequencer: load-use detection, mult/div EX
// occupancy, taken-branch flush and saturating performance counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_muldiv_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  cnt_clr_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_write_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
  output logic                  md_busy_o,
  output logic                  md_done_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  // The entry cycle counts as one occupancy cycle and the release
  // cycle as another, so the timer covers the remaining MD_LATENCY-2.
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);

  md_state_e             r_state;
  md_state_e             w_nextState;
  logic                  w_loadUse;
  logic                  w_tmrLoad;
  logic                  w_tmrDec;
  logic                  w_tmrZero;
  logic                  w_flushEvt;
  logic [MD_CNT_W-1:0]   w_tmrCount;
  logic [CNT_W-1:0]      r_stallCnt;
  logic [CNT_W-1:0]      r_flushCnt;

  assign w_loadUse = ex_mem_read_i && (ex_rt_i != '0) &&
                     ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  hazard_md_timer #(.W(MD_CNT_W)) u_md_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (w_tmrLoad),
    .load_val_i (MD_LOAD),
    .dec_i      (w_tmrDec),
    .count_o    (w_tmrCount),
    .zero_o     (w_tmrZero)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_state <= RUN;
    else
      r_state <= w_nextState;
  end

  // Next-state and prioritised output mux; reset forces a frozen, flushed pipe.
  always_comb begin
    w_nextState    = r_state;
    w_tmrLoad      = 1'b0;
    w_tmrDec       = 1'b0;
    w_flushEvt     = 1'b0;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    md_busy_o      = 1'b0;
    md_done_o      = 1'b0;
    if (!rst_n_i) begin
      w_nextState   = RUN;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_write_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            w_flushEvt    = 1'b1;
          end else if (ex_muldiv_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_flush_o = 1'b1;
            w_tmrLoad      = 1'b1;
            w_nextState    = MD_WAIT;
          end else if (w_loadUse) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
        MD_WAIT: begin
          md_busy_o = 1'b1;
          if (!w_tmrZero) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_flush_o = 1'b1;
            w_tmrDec       = 1'b1;
          end else begin
            md_done_o   = 1'b1;
            w_nextState = RUN;
          end
        end
        default: w_nextState = RUN;
      endcase
    end
  end

  // Saturating stall counter; clear beats a coincident increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_stallCnt <= '0;
    else if (cnt_clr_i)
      r_stallCnt <= '0;
    else if (!pc_write_o && (r_stallCnt != '1))
      r_stallCnt <= r_stallCnt + CNT_W'(1);
  end

  // Saturating taken-branch flush counter; clear beats a coincident increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_flushCnt <= '0;
    else if (cnt_clr_i)
      r_flushCnt <= '0;
    else if (w_flushEvt && (r_flushCnt != '1))
      r_flushCnt <= r_flushCnt + CNT_W'(1);
  end

  assign stall_cnt_o = r_stallCnt;
  assign flush_cnt_o = r_flushCnt;

  // Timer value is only needed through its zero flag here.
  logic w_unusedCount;
  assign w_unusedCount = ^w_tmrCount;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit.
// Main DUT uses MD_LATENCY=4; a second instance uses MD_LATENCY=2.
module tb_hazard_ctrl_unit;

  // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write,
  // id_ex_flush, ex_mem_flush, md_busy, md_done
  localparam logic [7:0] V_DEF = 8'b1101_0000;
  localparam logic [7:0] V_RST = 8'b0010_1000;
  localparam logic [7:0] V_BR  = 8'b1111_1000;
  localparam logic [7:0] V_LU  = 8'b0001_1000;
  localparam logic [7:0] V_MDE = 8'b0000_0100;
  localparam logic [7:0] V_MDW = 8'b0000_0110;
  localparam logic [7:0] V_MDR = 8'b1101_0011;

  logic        clk;
  logic        rstN;
  logic [4:0]  idRs, idRt, exRt;
  logic        idUsesRt, exMemRead, exMuldiv, exBranchTaken, cntClr;

  logic        pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemFlush, mdBusy, mdDone;
  logic [15:0] stallCnt, flushCnt;
  logic        pcWrite2, ifIdWrite2, ifIdFlush2, idExWrite2, idExFlush2, exMemFlush2, mdBusy2, mdDone2;
  logic [15:0] stallCnt2, flushCnt2;
  logic [7:0]  ctrl, ctrl2;

  int checkCount = 0;
  int passCount  = 0;

  assign ctrl  = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemFlush, mdBusy, mdDone};
  assign ctrl2 = {pcWrite2, ifIdWrite2, ifIdFlush2, idExWrite2, idExFlush2, exMemFlush2, mdBusy2, mdDone2};

  hazard_ctrl_unit #(.REG_ADDR_W(5), .MD_LATENCY(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rstN),
    .id_rs_i(idRs), .id_rt_i(idRt), .id_uses_rt_i(idUsesRt),
    .ex_rt_i(exRt), .ex_mem_read_i(exMemRead), .ex_muldiv_i(exMuldiv),
    .ex_branch_taken_i(exBranchTaken), .cnt_clr_i(cntClr),
    .pc_write_o(pcWrite), .if_id_write_o(ifIdWrite), .if_id_flush_o(ifIdFlush),
    .id_ex_write_o(idExWrite), .id_ex_flush_o(idExFlush), .ex_mem_flush_o(exMemFlush),
    .md_busy_o(mdBusy), .md_done_o(mdDone),
    .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .MD_LATENCY(2), .CNT_W(16)) dut2 (
    .clk_i(clk), .rst_n_i(rstN),
    .id_rs_i(idRs), .id_rt_i(idRt), .id_uses_rt_i(idUsesRt),
    .ex_rt_i(exRt), .ex_mem_read_i(exMemRead), .ex_muldiv_i(exMuldiv),
    .ex_branch_taken_i(exBranchTaken), .cnt_clr_i(cntClr),
    .pc_write_o(pcWrite2), .if_id_write_o(ifIdWrite2), .if_id_flush_o(ifIdFlush2),
    .id_ex_write_o(idExWrite2), .id_ex_flush_o(idExFlush2), .ex_mem_flush_o(exMemFlush2),
    .md_busy_o(mdBusy2), .md_done_o(mdDone2),
    .stall_cnt_o(stallCnt2), .flush_cnt_o(flushCnt2)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive all inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic [4:0] eRt, input logic memRead, input logic muldiv,
                               input logic br, input logic clr);
    idRs = rs; idRt = rt; idUsesRt = usesRt; exRt = eRt;
    exMemRead = memRead; exMuldiv = muldiv; exBranchTaken = br; cntClr = clr;
    #1;
  endtask

  // One comparison, counted and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Advance one clock and step off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_ctrl", 32'(ctrl), 32'(V_RST));
    checkOutput("reset_stall", 32'(stallCnt), 32'd0);
    checkOutput("reset_flush", 32'(flushCnt), 32'd0);
    tick();
    tick();
    rstN = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_ctrl", 32'(ctrl), 32'(V_DEF));

    $display("[TB] load-use on rs");
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs_ctrl", 32'(ctrl), 32'(V_LU));
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_after_ctrl", 32'(ctrl), 32'(V_DEF));
    checkOutput("lu_stall_cnt", 32'(stallCnt), 32'd1);

    $display("[TB] load to $0 never stalls");
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_r0_ctrl", 32'(ctrl), 32'(V_DEF));
    tick();
    checkOutput("lu_r0_stall_cnt", 32'(stallCnt), 32'd1);

    $display("[TB] rt match gated by id_uses_rt");
    applyStimulus(5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rt_unused_ctrl", 32'(ctrl), 32'(V_DEF));
    applyStimulus(5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rt_used_ctrl", 32'(ctrl), 32'(V_LU));
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rt_stall_cnt", 32'(stallCnt), 32'd2);

    $display("[TB] taken branch");
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("br_ctrl", 32'(ctrl), 32'(V_BR));
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_flush_cnt", 32'(flushCnt), 32'd1);

    $display("[TB] taken branch beats load-use");
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("br_lu_ctrl", 32'(ctrl), 32'(V_BR));
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_lu_flush_cnt", 32'(flushCnt), 32'd2);
    checkOutput("br_lu_stall_cnt", 32'(stallCnt), 32'd2);

    $display("[TB] mult/div sequence");
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("md_c1_ctrl", 32'(ctrl), 32'(V_MDE));
    checkOutput("md2_c1_ctrl", 32'(ctrl2), 32'(V_MDE));
    tick();
    checkOutput("md_c2_ctrl", 32'(ctrl), 32'(V_MDW));
    checkOutput("md2_c2_ctrl", 32'(ctrl2), 32'(V_MDR));
    tick();
    checkOutput("md_c3_ctrl", 32'(ctrl), 32'(V_MDW));
    tick();
    checkOutput("md_c4_ctrl", 32'(ctrl), 32'(V_MDR));
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("md_after_ctrl", 32'(ctrl), 32'(V_DEF));
    checkOutput("md_stall_cnt", 32'(stallCnt), 32'd5);

    $display("[TB] branch and load-use ignored during mult/div");
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mdi_c1_ctrl", 32'(ctrl), 32'(V_MDE));
    checkOutput("mdi2_c1_ctrl", 32'(ctrl2), 32'(V_MDE));
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("mdi_c2_ctrl", 32'(ctrl), 32'(V_MDW));
    checkOutput("mdi2_c2_ctrl", 32'(ctrl2), 32'(V_MDR));
    tick();
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mdi_c3_ctrl", 32'(ctrl), 32'(V_MDW));
    tick();
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("mdi_c4_ctrl", 32'(ctrl), 32'(V_MDR));
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mdi_after_ctrl", 32'(ctrl), 32'(V_DEF));
    checkOutput("mdi_stall_cnt", 32'(stallCnt), 32'd8);
    checkOutput("mdi_flush_cnt", 32'(flushCnt), 32'd2);

    $display("[TB] reset in the middle of mult/div");
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("mdr_c2_ctrl", 32'(ctrl), 32'(V_MDW));
    tick();
    rstN = 1'b0;
    #1;
    checkOutput("mdr_reset_ctrl", 32'(ctrl), 32'(V_RST));
    checkOutput("mdr_reset_stall", 32'(stallCnt), 32'd0);
    checkOutput("mdr_reset_flush", 32'(flushCnt), 32'd0);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("mdr_release_ctrl", 32'(ctrl), 32'(V_DEF));
    tick();
    checkOutput("mdr_next_ctrl", 32'(ctrl), 32'(V_DEF));
    checkOutput("mdr_next_stall", 32'(stallCnt), 32'd0);

    $display("[TB] stall counter saturation and clear");
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_lu_ctrl", 32'(ctrl), 32'(V_LU));
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat_fffe", 32'(stallCnt), 32'h0000_FFFE);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sat_ffff", 32'(stallCnt), 32'h0000_FFFF);
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("clr_stall", 32'(stallCnt), 32'd0);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("clr_idle_stall", 32'(stallCnt), 32'd0);
    checkOutput("clr_idle_ctrl", 32'(ctrl), 32'(V_DEF));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
